// File: rtl/uart_rx_engine_if.sv
// Byte-delivery handshake between the UART receiver and its consumer.
// The receiver drives data, valid and per-frame flags; the consumer drives ready.
interface uart_rx_engine_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_parity_err;
  logic       rx_frame_err;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_parity_err,
    output rx_frame_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  rx_parity_err,
    input  rx_frame_err,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver: synchronizes the pin, deframes start/data/parity/stop
// using the live config fields, and hands bytes plus error flags to a valid/ready consumer.
module uart_rx_engine #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             clk_div,
  input  logic                    check_en,
  input  logic [1:0]              check_type,
  input  logic [1:0]              data_bit,
  input  logic [1:0]              stop_bit,
  input  logic                    uart_rx,
  uart_rx_engine_if.master        rx_if,
  output logic                    rx_overrun,
  output logic                    rx_busy,
  output logic [15:0]             rx_byte_count
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   rxs_q;
  logic [31:0]            baud_q;
  logic [2:0]             bit_q;
  logic [7:0]             shift_q;
  logic                   perr_q;
  logic                   ferr_q;
  logic                   done_q;
  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   perr_out_q;
  logic                   ferr_out_q;
  logic                   ovr_q;
  logic                   busy_q;
  logic [15:0]            cnt_q;

  logic [31:0]            half_m1;
  logic [31:0]            full_m1;
  logic [2:0]             last_bit;
  logic                   unused_stop_cfg;

  // Only the first stop bit is sampled; extra stop time is absorbed by idle edge detection.
  assign unused_stop_cfg = ^stop_bit;

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign half_m1  = (clk_div >> 1) - 32'd1;
  assign full_m1  = clk_div - 32'd1;
  assign last_bit = {1'b0, data_bit} + 3'd4;

  function automatic logic parity_expected(input logic [7:0] d, input logic [1:0] t);
    case (t)
      2'b00:   return ^d;
      2'b01:   return ~(^d);
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '1;
      rxs_q      <= 1'b1;
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
      rxs_q  <= rxs;
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (rxs_q && !rxs) begin
            state_q <= START;
            baud_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_q == half_m1) begin
            if (rxs) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= DATA;
              baud_q  <= '0;
              bit_q   <= '0;
              shift_q <= '0;
              perr_q  <= 1'b0;
              ferr_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + 32'd1;
          end
        end
        DATA: begin
          if (baud_q == full_m1) begin
            baud_q         <= '0;
            shift_q[bit_q] <= rxs;
            if (bit_q == last_bit) begin
              state_q <= check_en ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + 32'd1;
          end
        end
        PARITY: begin
          if (baud_q == full_m1) begin
            baud_q  <= '0;
            perr_q  <= (rxs != parity_expected(shift_q, check_type));
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + 32'd1;
          end
        end
        STOP: begin
          if (baud_q == full_m1) begin
            baud_q  <= '0;
            ferr_q  <= ~rxs;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= cnt_q + 16'd1;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // A completed frame wins over acceptance; it only counts as overrun if unaccepted.
      if (done_q) begin
        data_q     <= shift_q;
        perr_out_q <= perr_q;
        ferr_out_q <= ferr_q;
        valid_q    <= 1'b1;
        if (valid_q && !rx_if.rx_ready) begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_valid      = valid_q;
  assign rx_if.rx_parity_err = perr_out_q;
  assign rx_if.rx_frame_err  = ferr_out_q;
  assign rx_overrun          = ovr_q;
  assign rx_busy             = busy_q;
  assign rx_byte_count       = cnt_q;

endmodule
